// File: rtl/vid_timing_pkg.sv
// Shared types and timing arithmetic for the CMOS/DVP timing generator.
package vid_timing_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} tg_state_t;

  function automatic int h_total(int sync, int back, int disp, int front);
    return sync + back + disp + front;
  endfunction

  function automatic int v_total(int sync, int back, int disp, int front);
    return sync + back + disp + front;
  endfunction

  // BMP rows are padded to a multiple of 4 bytes.
  function automatic int row_stride(int hdisp, int bpp);
    return (hdisp * bpp + 3) & ~3;
  endfunction

endpackage

// File: rtl/vid_addr_gen.sv
// Pixel coordinate and BMP byte-address generator; row base is accumulated
// line by line so no multiplier sits on the row index.
module vid_addr_gen
  import vid_timing_pkg::*;
#(
  parameter int H_DISP    = 640,
  parameter int V_DISP    = 480,
  parameter int BPP       = 3,
  parameter int HDR_BYTES = 54,
  parameter int AW        = 21
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          clr_i,
  input  logic          tick_i,
  input  logic          h_act_i,
  input  logic          v_act_i,
  input  logic          line_end_i,
  input  logic          frame_end_i,
  input  logic          bottom_up_i,
  input  logic          rd_en_i,
  output logic [AW-1:0] rd_addr_o,
  output logic [10:0]   pix_x_o,
  output logic [10:0]   pix_y_o
);

  localparam int STRIDE = row_stride(H_DISP, BPP);
  localparam logic [AW-1:0] HDR_BASE = AW'(HDR_BYTES);
  localparam logic [AW-1:0] TOP_BASE = AW'(HDR_BYTES + (V_DISP - 1) * STRIDE);

  logic [10:0]   px_q, px_d, py_q, py_d;
  logic [AW-1:0] col_q, col_d, roff_q, roff_d;
  logic [AW-1:0] row_base;

  always_comb begin
    px_d   = px_q;
    col_d  = col_q;
    py_d   = py_q;
    roff_d = roff_q;
    if (clr_i || !h_act_i || line_end_i) begin
      px_d  = '0;
      col_d = '0;
    end else if (tick_i) begin
      px_d  = px_q + 1'b1;
      col_d = col_q + AW'(BPP);
    end
    if (clr_i || !v_act_i || frame_end_i) begin
      py_d   = '0;
      roff_d = '0;
    end else if (line_end_i) begin
      py_d   = py_q + 1'b1;
      roff_d = roff_q + AW'(STRIDE);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      px_q   <= '0;
      col_q  <= '0;
      py_q   <= '0;
      roff_q <= '0;
    end else begin
      px_q   <= px_d;
      col_q  <= col_d;
      py_q   <= py_d;
      roff_q <= roff_d;
    end
  end

  // Bottom-up walks down from the last stored row.
  assign row_base  = bottom_up_i ? (TOP_BASE - roff_q) : (HDR_BASE + roff_q);
  assign rd_addr_o = rd_en_i ? (row_base + col_q) : '0;
  assign pix_x_o   = rd_en_i ? px_q : '0;
  assign pix_y_o   = rd_en_i ? py_q : '0;

endmodule

// File: rtl/cmos_timing_gen.sv
// CMOS/DVP timing source: frame FSM, pixel/line counters and read-latency
// alignment of vsync/href/clken.
//   state    | meaning
//   IDLE     | counters held at 0, config latched on leaving
//   RUN      | generating frames, start high
//   STOPPING | start low, finishing the current frame
module cmos_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int H_DISP    = 640,
  parameter int V_DISP    = 480,
  parameter int H_SYNC    = 5,
  parameter int H_BACK    = 5,
  parameter int H_FRONT   = 5,
  parameter int V_SYNC    = 1,
  parameter int V_BACK    = 0,
  parameter int V_FRONT   = 1,
  parameter int BPP       = 3,
  parameter int HDR_BYTES = 54,
  parameter int RD_LAT    = 2,
  parameter int AW        = 21,
  parameter int FCW       = 16
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           start,
  input  logic           continuous,
  input  logic [FCW-1:0] frame_num,
  input  logic [3:0]     clk_div,
  input  logic           bottom_up,
  output logic           rd_en,
  output logic [AW-1:0]  rd_addr,
  output logic [10:0]    pix_x,
  output logic [10:0]    pix_y,
  output logic           frame_vsync,
  output logic           frame_href,
  output logic           frame_clken,
  output logic [FCW-1:0] frame_cnt,
  output logic           frame_done,
  output logic           busy
);

  localparam int CW      = 12;
  localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HA_LO  = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] HA_HI  = CW'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CW-1:0] VA_LO  = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] VA_HI  = CW'(V_SYNC + V_BACK + V_DISP);
  localparam logic [CW-1:0] VS_END = CW'(V_SYNC);

  tg_state_t      state_q, state_d;
  logic [3:0]     divcnt_q, divcnt_d;
  logic [CW-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [3:0]     div_q;
  logic           bu_q, cont_q;
  logic [FCW-1:0] fnum_q;

  logic           run, tick, h_last, v_last, line_end, frame_end;
  logic           h_act, v_act, rd_en0, href0, vsync0, cfg_ld, last_frame;
  logic [FCW-1:0] fnum_eff;
  logic [FCW:0]   fcnt_inc;
  logic [2:0]     stage0;

  assign run       = (state_q != IDLE);
  assign tick      = run && (divcnt_q == div_q);
  assign h_last    = (hcnt_q == H_LAST);
  assign v_last    = (vcnt_q == V_LAST);
  assign line_end  = tick && h_last;
  assign frame_end = line_end && v_last;
  assign h_act     = (hcnt_q >= HA_LO) && (hcnt_q < HA_HI);
  assign v_act     = (vcnt_q >= VA_LO) && (vcnt_q < VA_HI);
  assign rd_en0    = tick && h_act && v_act;
  assign href0     = run && h_act && v_act;
  assign vsync0    = run && (vcnt_q >= VS_END);

  // frame_num of 0 behaves as a single frame.
  assign fnum_eff   = (fnum_q == '0) ? FCW'(1) : fnum_q;
  assign fcnt_inc   = {1'b0, fcnt_q} + 1'b1;
  assign last_frame = (fcnt_inc >= {1'b0, fnum_eff});

  always_comb begin
    state_d = state_q;
    cfg_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cfg_ld  = 1'b1;
        end
      end
      RUN, STOPPING: begin
        // A start level seen at the frame-end tick overrides an earlier drop.
        if (frame_end && (!start || (!cont_q && last_frame))) state_d = IDLE;
        else state_d = start ? RUN : STOPPING;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    divcnt_d = '0;
    hcnt_d   = '0;
    vcnt_d   = '0;
    if (run) begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (tick) begin
        hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
        if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
      end else begin
        divcnt_d = divcnt_q + 1'b1;
      end
    end
    fcnt_d = fcnt_q;
    if (cfg_ld) fcnt_d = '0;
    else if (frame_end && (fcnt_q != '1)) fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      divcnt_q <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      fcnt_q   <= '0;
      div_q    <= '0;
      bu_q     <= 1'b0;
      cont_q   <= 1'b0;
      fnum_q   <= '0;
    end else begin
      state_q  <= state_d;
      divcnt_q <= divcnt_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      fcnt_q   <= fcnt_d;
      if (cfg_ld) begin
        div_q  <= clk_div;
        bu_q   <= bottom_up;
        cont_q <= continuous;
        fnum_q <= frame_num;
      end
    end
  end

  vid_addr_gen #(
    .H_DISP    (H_DISP),
    .V_DISP    (V_DISP),
    .BPP       (BPP),
    .HDR_BYTES (HDR_BYTES),
    .AW        (AW)
  ) u_addr (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .clr_i       (!run),
    .tick_i      (tick),
    .h_act_i     (h_act),
    .v_act_i     (v_act),
    .line_end_i  (line_end),
    .frame_end_i (frame_end),
    .bottom_up_i (bu_q),
    .rd_en_i     (rd_en0),
    .rd_addr_o   (rd_addr),
    .pix_x_o     (pix_x),
    .pix_y_o     (pix_y)
  );

  assign stage0 = {vsync0, href0, rd_en0};

  generate
    if (RD_LAT == 0) begin : g_nodly
      assign {frame_vsync, frame_href, frame_clken} = stage0;
    end else begin : g_dly
      logic [2:0] pipe_q [RD_LAT];
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= stage0;
          for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign {frame_vsync, frame_href, frame_clken} = pipe_q[RD_LAT-1];
    end
  endgenerate

  assign rd_en      = rd_en0;
  assign frame_done = frame_end;
  assign frame_cnt  = fcnt_q;
  assign busy       = run;

endmodule
